// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, bit 7 = g down to bit 1 = a.
package seg7_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned N_CODES = 16;

    typedef logic [7:1] seg7_t;

    localparam seg7_t      SEG_BLANK = 7'h7F;
    localparam seg7_t      SEG_DASH  = 7'h3F;
    localparam logic [3:0] BCD_BLANK = 4'hA;

    // Indexed by the 4-bit code; A..E blank, F shows only segment g.
    localparam seg7_t SEG_TABLE [N_CODES] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_DASH
    };

    function automatic seg7_t seg7_lookup(input logic [BCD_W-1:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD-to-segment decode with a forced-blank override.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] i_code,
    input  logic             i_blank,
    output seg7_t            o_seven_n_c
);

    always_comb begin
        o_seven_n_c = seg7_lookup(i_code);
        if (i_blank) begin
            o_seven_n_c = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-aligned
// shadow update. Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BCD_W*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]       dp_in,
    output logic [7:1]                seven,
    output logic                      dp_n,
    output logic [N_DIGITS-1:0]       digit_en_n,
    output logic                      frame_start
);

    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned WORD_W = BCD_W * N_DIGITS;

    localparam logic [CNT_W-1:0]    PRESC_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_MAX    = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_ONE    = N_DIGITS'(1);
    localparam logic [WORD_W-1:0]   BLANK_WORD = {N_DIGITS{BCD_BLANK}};

    logic [CNT_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_pend_bcd;
    logic [N_DIGITS-1:0] r_pend_dp;
    logic                r_pend_valid;
    logic [WORD_W-1:0]   r_disp_bcd;
    logic [N_DIGITS-1:0] r_disp_dp;
    logic                r_showing0;

    logic                w_tick;
    logic                w_swap;
    logic [BCD_W-1:0]    w_code;
    logic [N_DIGITS-1:0] w_lz_blank;
    logic                w_blank;
    seg7_t               w_seven_n;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_swap = w_tick && (r_idx == IDX_MAX) && r_pend_valid;

    // Prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Pending shadow and display registers; display changes only at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_bcd   <= BLANK_WORD;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_disp_bcd   <= BLANK_WORD;
            r_disp_dp    <= '0;
        end else begin
            if (load) begin
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
            end
            if (w_swap) begin
                r_disp_bcd <= r_pend_bcd;
                r_disp_dp  <= r_pend_dp;
            end
            r_pend_valid <= load | (r_pend_valid & ~w_swap);
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_lz_run;

    // Blank zeros from the top digit down until the first non-zero code.
    always_comb begin
        w_lz_blank = '0;
        w_lz_run   = 1'b1;
        for (int j = int'(N_DIGITS) - 1; j >= 1; j--) begin
            if (w_lz_run && (r_disp_bcd[BCD_W*j +: BCD_W] == 4'h0)) begin
                w_lz_blank[j] = 1'b1;
            end else begin
                w_lz_run = 1'b0;
            end
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_code  = r_disp_bcd[{r_idx, 2'b00} +: BCD_W];
    assign w_blank = w_lz_blank[r_idx];

    seg7_digit_decode u_decode (
        .i_code      (w_code),
        .i_blank     (w_blank),
        .o_seven_n_c (w_seven_n)
    );

    // Registered outputs lag r_idx by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seven       <= SEG_BLANK;
            dp_n        <= 1'b1;
            digit_en_n  <= '1;
            frame_start <= 1'b0;
            r_showing0  <= 1'b0;
        end else begin
            seven       <= w_seven_n;
            dp_n        <= ~r_disp_dp[r_idx];
            digit_en_n  <= ~(DIG_ONE << r_idx);
            frame_start <= (r_idx == '0) && !r_showing0;
            r_showing0  <= (r_idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with N_DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [7:1]  seven;
    logic        dp_n;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS (4),
        .SCAN_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .seven       (seven),
        .dp_n        (dp_n),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic load_at(input int t, input logic [15:0] b, input logic [3:0] d);
        run_to(t - 1);
        load   = 1'b1;
        bcd_in = b;
        dp_in  = d;
        step();
        load   = 1'b0;
    endtask

    task automatic chk_digit(input int t, input logic [6:0] s, input logic dpn, input logic [3:0] en);
        run_to(t);
        chk($sformatf("seven_k%0d", t), 32'(seven), 32'(s));
        chk($sformatf("dp_n_k%0d", t), 32'(dp_n), 32'(dpn));
        chk($sformatf("en_k%0d", t), 32'(digit_en_n), 32'(en));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_seven"}, 32'(seven), 32'h7F);
        chk({tag, "_dp_n"}, 32'(dp_n), 32'h1);
        chk({tag, "_en"}, 32'(digit_en_n), 32'hF);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    function automatic logic [3:0] exp_en(input int t);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (((t - 1) / 4) % 4));
    endfunction

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = '0;
        dp_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");

        rst = 1'b0;
        k   = 0;
        // Scan order, frame pulse, blank display after reset.
        for (int t = 1; t <= 16; t++) begin
            run_to(t);
            chk($sformatf("scan_en_k%0d", t), 32'(digit_en_n), 32'(exp_en(t)));
            chk($sformatf("scan_fs_k%0d", t), 32'(frame_start), 32'(((t - 1) % 16) == 0));
            chk($sformatf("scan_seven_k%0d", t), 32'(seven), 32'h7F);
        end

        // Mid-frame load of 1234 stays hidden until the frame wraps.
        load_at(21, 16'h1234, 4'b0100);
        for (int t = 21; t <= 32; t++) begin
            run_to(t);
            chk($sformatf("hold_seven_k%0d", t), 32'(seven), 32'h7F);
        end
        chk_digit(33, 7'h19, 1'b1, 4'b1110);
        chk("fs_k33", 32'(frame_start), 32'h1);
        chk_digit(37, 7'h30, 1'b1, 4'b1101);
        chk_digit(41, 7'h24, 1'b0, 4'b1011);
        chk_digit(45, 7'h79, 1'b1, 4'b0111);

        // 1234 pending, 5678 loaded on the swap edge: 1234 frame then 5678 frame.
        load_at(46, 16'h1234, 4'b0100);
        load_at(48, 16'h5678, 4'b0000);
        chk_digit(49, 7'h19, 1'b1, 4'b1110);
        chk_digit(53, 7'h30, 1'b1, 4'b1101);
        chk_digit(57, 7'h24, 1'b0, 4'b1011);
        chk_digit(61, 7'h79, 1'b1, 4'b0111);
        chk_digit(65, 7'h00, 1'b1, 4'b1110);
        chk_digit(69, 7'h78, 1'b1, 4'b1101);
        chk_digit(73, 7'h02, 1'b1, 4'b1011);
        chk_digit(77, 7'h12, 1'b1, 4'b0111);

        // Codes B,C,D,E blank every digit while dp still follows dp_in.
        load_at(84, 16'hEDCB, 4'b1010);
        chk_digit(93, 7'h12, 1'b1, 4'b0111);
        chk_digit(97, 7'h7F, 1'b1, 4'b1110);
        chk_digit(101, 7'h7F, 1'b0, 4'b1101);
        chk_digit(105, 7'h7F, 1'b1, 4'b1011);
        chk_digit(109, 7'h7F, 1'b0, 4'b0111);

        // 00F0: dash on digit 1, leading zeros depend on the build option.
        load_at(116, 16'h00F0, 4'b0000);
        chk_digit(129, 7'h40, 1'b1, 4'b1110);
        chk_digit(133, 7'h3F, 1'b1, 4'b1101);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk_digit(137, 7'h7F, 1'b1, 4'b1011);
        chk_digit(141, 7'h7F, 1'b1, 4'b0111);
`else
        chk_digit(137, 7'h40, 1'b1, 4'b1011);
        chk_digit(141, 7'h40, 1'b1, 4'b0111);
`endif

        // Reset while idx = 2 with a fresh value pending; pending must be lost.
        load_at(152, 16'h1111, 4'b1111);
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        k   = 0;
        chk_reset_outs("midrst_held");
        chk_digit(1, 7'h7F, 1'b1, 4'b1110);
        chk("restart_fs_k1", 32'(frame_start), 32'h1);
        chk_digit(5, 7'h7F, 1'b1, 4'b1101);
        chk_digit(17, 7'h7F, 1'b1, 4'b1110);
        chk("restart_fs_k17", 32'(frame_start), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display, built around a BCD-to-segment decode.
- Captures a packed BCD word plus per-digit decimal points on a load strobe.
- Swaps in new data only at frame boundaries, so the display never tears.
- Scans one digit at a time at a programmable rate with active-low segment and digit outputs.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clock cycles each digit stays lit (>=2).
- CNT_W, $clog2(SCAN_DIV), prescaler width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  one-cycle strobe; captures bcd_in and dp_in.
- bcd_in  in  4*N_DIGITS  packed digits; [3:0] is digit 0 (least significant, rightmost).
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
- seven  out  7 ([7:1])  segments, active-low; bit 1 = a … bit 7 = g.
- dp_n  out  1  decimal point, active-low.
- digit_en_n  out  N_DIGITS  digit enables, active-low, one-hot-low.
- frame_start  out  1  one-cycle pulse when digit 0 is selected.

Behaviour:
- Reset (async on rst high):
  - prescaler = 0, idx = 0.
  - pending and display registers = all digits 4'hA (blank), all dp = 0, pending_valid = 0.
  - Outputs: seven = 7'h7F, dp_n = 1, digit_en_n = all ones, frame_start = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps; tick = (prescaler == SCAN_DIV-1).
  - On tick, idx increments, wrapping N_DIGITS-1 -> 0.
- Load:
  - When load = 1, pending <= {bcd_in, dp_in} and pending_valid <= 1.
  - Back-to-back loads: the last one wins.
- Frame swap:
  - Occurs on tick with idx == N_DIGITS-1 and pending_valid = 1.
  - display <= pending, pending_valid <= 0.
  - If load coincides with the swap cycle: the swap uses the old pending value; the new load is captured into pending and pending_valid stays 1, so it is applied at the next frame.
- Outputs:
  - Registered from the current idx and display register, so they lag idx by exactly one clock.
  - digit_en_n[idx] = 0, all others 1.
  - frame_start = 1 for one cycle on the first output cycle with idx == 0.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 4'hA..4'hE = 1111111 (blank).
  - 4'hF = 0111111 (dash, g only).
- dp_n = ~display_dp[idx]; a blanked digit still shows its dp.
- Reset mid-scan: outputs go to the reset values immediately and asynchronously; pending data is lost.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Zeros from digit N_DIGITS-1 downward are decoded as blank until the first non-zero digit.
  - Digit 0 is never blanked.
  - Non-BCD codes stop the suppression.
  - Suppression is computed from the display register.
- Undefined: every digit decodes literally.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F.
  - The digit-pattern constant array.
  - Typedef seg7_t (logic [7:1]).
- One sub-module, seg7_digit_decode: 4-bit code plus a blank input -> seven_n, purely combinational.
- The scan, prescaler and shadow logic stay in the top level.

Test Plan:
- Reset, then release with N_DIGITS=4, SCAN_DIV=4:
  - seven = 7'h7F until the first output edge, then all digits blank.
  - digit_en_n sequences 1110, 1101, 1011, 0111, every 4 cycles.
  - frame_start pulses every 16 cycles.
- load with bcd_in = 16'h1234, dp_in = 4'b0100 mid-frame:
  - The display keeps blank until the frame wraps.
  - Next frame, digit 0 shows 0011001 (4) and digit 2 shows 0100100 (2) with dp_n = 0.
- load 16'h5678 on the exact swap cycle while 16'h1234 is pending:
  - The frame shows 1234.
  - The following frame shows 5678.
- bcd_in = 16'h00F0 with the macro defined:
  - Digits 3 and 2 are blank, digit 1 is a dash, digit 0 shows 1000000.
  - Without the macro, digits 3 and 2 show 1000000.
- Assert rst for 1 cycle mid-scan (idx = 2):
  - Outputs go to reset values within the same cycle.
  - Scan restarts at digit 0.
- Codes A..E on all digits -> seven = 7'h7F on every digit; dp follows dp_in.
